// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store unit to word-wide memory port
// IDLE -> ACCESS (one mem_en cycle) -> RESP; rejected requests skip ACCESS.
module lsu_mem_ctrl #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        reject;
  logic        access;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic [3:0]  strb;
  logic [31:0] repl;

  always_comb begin
    reject = ALIGN_CHECK && ((req_size == 2'd3) ||
                             (req_size == 2'd1 && req_addr[0]) ||
                             (req_size == 2'd2 && req_addr[1:0] != 2'b00));
  end

  // Lane extraction works on the latched address; size 3 only reaches here when unchecked.
  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    load_ext = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0: begin
        strb = 4'b0001 << addr_q[1:0];
        repl = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        strb = 4'b0011 << addr_q[1:0];
        repl = {2{wdata_q[15:0]}};
      end
      default: begin
        strb = 4'b1111;
        repl = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = reject;
          state_d = reject ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        rdata_d = wr_q ? 32'd0 : load_ext;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory port is decoded straight from state so reset drops it without waiting for a clock.
  always_comb begin
    access     = (state_q == S_ACCESS);
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_en     = access;
    mem_wr     = access & wr_q;
    mem_addr   = access ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wstrb  = (access && wr_q) ? strb : 4'd0;
    mem_wdata  = (access && wr_q) ? repl : 32'd0;
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr, req_unsigned, resp_ready;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [1:0]  req_size;

  logic        req_ready, resp_valid, resp_err, mem_en, mem_wr;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        na_req_ready, na_resp_valid, na_resp_err, na_mem_en, na_mem_wr;
  logic [31:0] na_resp_rdata, na_mem_addr, na_mem_wdata;
  logic [3:0]  na_mem_wstrb;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int c0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en === 1'b1) en_cnt++;

  lsu_mem_ctrl u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  lsu_mem_ctrl #(.ALIGN_CHECK(1'b0)) u_na (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(na_req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(na_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(na_resp_rdata), .resp_err(na_resp_err), .mem_en(na_mem_en),
    .mem_wr(na_mem_wr), .mem_addr(na_mem_addr), .mem_wdata(na_mem_wdata),
    .mem_wstrb(na_mem_wstrb), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_wr = ~wr; req_addr = 32'h5555_5557; req_size = 2'd3;
    req_unsigned = ~u; req_wdata = ~wd;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF);
    chk("sw_mem_en", {31'd0, mem_en}, 32'd1);
    chk("sw_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
    chk("sw_addr", mem_addr, 32'h8000_0010);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_req_ready", {31'd0, req_ready}, 32'd0);
    chk("sw_resp_early", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("sw_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("sw_resp_err", {31'd0, resp_err}, 32'd0);
    chk("sw_resp_rdata", resp_rdata, 32'd0);
    chk("sw_resp_mem_en", {31'd0, mem_en}, 32'd0);
    chk("sw_resp_addr", mem_addr, 32'd0);
    chk("sw_resp_wdata", mem_wdata, 32'd0);
    release_resp();
    chk("sw_exit_valid", {31'd0, resp_valid}, 32'd0);
    chk("sw_exit_ready", {31'd0, req_ready}, 32'd1);

    resp_ready = 1'b1;
    issue(1'b1, 32'h8000_0003, 2'd0, 1'b0, 32'h0000_00A5);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", mem_addr, 32'h8000_0000);
    @(negedge clk);
    chk("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
    @(negedge clk);
    chk("sb_exit", {31'd0, resp_valid}, 32'd0);
    resp_ready = 1'b0;

    mem_rdata = 32'h12F0_3456;
    issue(1'b0, 32'h8000_0002, 2'd0, 1'b0, 32'hFFFF_FFFF);
    chk("lb_mem_en", {31'd0, mem_en}, 32'd1);
    chk("lb_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("lb_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("lb_addr", mem_addr, 32'h8000_0000);
    @(negedge clk);
    chk("lb_signed", resp_rdata, 32'hFFFF_FFF0);
    release_resp();

    issue(1'b0, 32'h8000_0002, 2'd0, 1'b1, 32'd0);
    @(negedge clk);
    chk("lbu_unsigned", resp_rdata, 32'h0000_00F0);
    release_resp();

    c0 = en_cnt;
    issue(1'b0, 32'h8000_0001, 2'd1, 1'b0, 32'd0);
    chk("lh_mis_valid", {31'd0, resp_valid}, 32'd1);
    chk("lh_mis_err", {31'd0, resp_err}, 32'd1);
    chk("lh_mis_rdata", resp_rdata, 32'd0);
    chk("lh_mis_mem_en", {31'd0, mem_en}, 32'd0);
    chk("lh_na_mem_en", {31'd0, na_mem_en}, 32'd1);
    @(negedge clk);
    chk("lh_mis_hold", {31'd0, resp_err}, 32'd1);
    chk("lh_mis_no_en", en_cnt - c0, 32'd0);
    chk("lh_na_valid", {31'd0, na_resp_valid}, 32'd1);
    chk("lh_na_err", {31'd0, na_resp_err}, 32'd0);
    chk("lh_na_rdata", na_resp_rdata, 32'hFFFF_F034);
    release_resp();

    issue(1'b1, 32'h8000_0003, 2'd1, 1'b0, 32'h0000_BEEF);
    chk("sh_mis_err", {31'd0, resp_err}, 32'd1);
    chk("sh_na_wstrb", {28'd0, na_mem_wstrb}, 32'h8);
    chk("sh_na_wdata", na_mem_wdata, 32'hBEEF_BEEF);
    chk("sh_na_addr", na_mem_addr, 32'h8000_0000);
    @(negedge clk);
    release_resp();

    issue(1'b0, 32'h8000_0002, 2'd3, 1'b0, 32'd0);
    chk("s3_mis_err", {31'd0, resp_err}, 32'd1);
    chk("s3_na_mem_en", {31'd0, na_mem_en}, 32'd1);
    @(negedge clk);
    chk("s3_na_rdata", na_resp_rdata, 32'h0000_12F0);
    release_resp();

    c0 = en_cnt;
    mem_rdata = 32'h89AB_CDEF;
    issue(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, 32'h89AB_CDEF);
      chk("stall_err", {31'd0, resp_err}, 32'd0);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      mem_rdata = $urandom;
      @(negedge clk);
    end
    chk("stall_en_pulses", en_cnt - c0, 32'd1);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h8000_0000; req_size = 2'd2;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("exit_no_accept_ready", {31'd0, req_ready}, 32'd1);
    chk("exit_no_accept_en", {31'd0, mem_en}, 32'd0);
    chk("exit_no_resp", {31'd0, resp_valid}, 32'd0);

    issue(1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'd0);
    chk("rstacc_en_before", {31'd0, mem_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstacc_en_drop", {31'd0, mem_en}, 32'd0);
    chk("rstacc_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstacc_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("rstacc_idle", {31'd0, req_ready}, 32'd1);
    end

    issue(1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    chk("rstresp_valid", {31'd0, resp_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstresp_drop", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstresp_none", {31'd0, resp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter: ALIGN_CHECK, default 1, meaning 1 = misaligned or illegal requests are rejected with resp_err; 0 = low address bits are used as given.
REQ-002 clock  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  upstream access request present.
REQ-005 req_ready  out  1  block can accept a request this cycle.
REQ-006 req_wr  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  upstream consumes the response.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  out  1  request was rejected; no memory access was made.
REQ-015 mem_en, mem_wr  out  1 each  memory-port enable and write select.
REQ-016 mem_addr  out  32  word-aligned address.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_wstrb  out  4  byte-lane write strobe.
REQ-019 mem_rdata  in  32  memory read data, valid combinationally in the same cycle as mem_en.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, when req_valid=1, the block SHALL latch wr, addr, size, unsigned and wdata.
REQ-023 From IDLE, an accepted request SHALL go to ACCESS, or straight to RESP with resp_err=1 when it is rejected.
REQ-024 A request is rejected (ALIGN_CHECK=1 only) when: size=3; size=1 with addr[0]=1; or size=2 with addr[1:0]!=0.
REQ-025 ACCESS SHALL last exactly one cycle, then go to RESP.
REQ-026 During ACCESS: mem_en=1, mem_wr=latched wr, and mem_addr={addr[31:2],2'b00}.
REQ-027 mem_en SHALL be 0 in every state other than ACCESS.
REQ-028 Outside ACCESS, mem_wr, mem_addr, mem_wdata and mem_wstrb SHALL all be 0.
REQ-029 Store strobe: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
REQ-030 For a load, mem_wstrb SHALL be 0.
REQ-031 Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-032 Load data: at the end of ACCESS, the block SHALL shift mem_rdata right by 8*addr[1:0].
REQ-033 The shifted load data SHALL then be truncated to the access size and sign- or zero-extended per req_unsigned, and registered as resp_rdata.
REQ-034 With ALIGN_CHECK=0, the strobe SHALL be masked to 4 bits (lanes shifted past bit 3 are dropped), and size=3 SHALL be treated as a word access.
REQ-035 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable.
REQ-036 RESP SHALL return to IDLE on the cycle in which resp_ready=1.
REQ-037 A new request SHALL NOT be accepted in the same cycle that RESP exits.
REQ-038 Latency: request accepted at edge N; mem_en=1 in cycle N+1; resp_valid=1 from cycle N+2 (rejected request: from N+1).
REQ-039 resp_ready while not in RESP SHALL be ignored.
REQ-040 req_* inputs after acceptance SHALL NOT affect the in-flight access.
REQ-041 Exactly one mem_en pulse SHALL occur per accepted non-rejected request, regardless of how long RESP stalls.

Reset
REQ-042 While reset=1, the FSM SHALL be held in IDLE, asynchronously, independent of clock.
REQ-043 Reset values: req_ready=1; resp_valid, resp_err and mem_en=0; all data, address and strobe outputs=0.
REQ-044 Reset asserted during ACCESS SHALL drop mem_en immediately.
REQ-045 Reset asserted during RESP SHALL discard the response; no response SHALL be produced after reset deasserts.

Verification
REQ-046 Store word 0xDEADBEEF to 0x80000010 -> one ACCESS cycle with mem_wstrb=1111, mem_addr=0x80000010, mem_wdata=0xDEADBEEF; then resp_valid=1, resp_err=0, resp_rdata=0.
REQ-047 Store byte 0xA5 to 0x80000003 -> mem_wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x80000000.
REQ-048 Load byte, signed, from 0x80000002 with mem_rdata=0x12F03456 -> resp_rdata=0xFFFFFFF0; the same load unsigned -> resp_rdata=0x000000F0.
REQ-049 Load half from 0x80000001 with ALIGN_CHECK=1 -> mem_en never asserts; resp_valid=1 with resp_err=1 one cycle after acceptance.
REQ-050 Hold resp_ready=0 for 5 cycles after a load -> resp_valid, resp_rdata and resp_err stay stable, mem_en pulses exactly once, and req_ready=0 throughout.
REQ-051 Assert reset mid-ACCESS -> mem_en falls within the same cycle, the block returns to IDLE with req_ready=1, and no resp_valid follows.
